bus_uart: RTL and testbench
===========================

BUS_UART -- requirements
Module: bus_uart

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 16, reset value of the clocks-per-bit divisor.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cs  input  1  bus select for this block's register page.
REQ-005 SHALL have port we  input  1  1 = CPU write, 0 = CPU read.
REQ-006 SHALL have port addr  input  2  register index (CPU_AB[1:0]).
REQ-007 SHALL have port din  input  8  write data from CPU.
REQ-008 SHALL have port dout  output  8  registered read data.
REQ-009 SHALL have port irq  output  1  interrupt request, active-high.
REQ-010 SHALL have port RX  input  1  serial receive line, idle high.
REQ-011 SHALL have port TX  output  1  serial transmit line, idle high.

Function
REQ-012 SHALL decode the register map as: 0 = data (write TX byte / read RX byte); 1 = status/control; 2 = divisor low; 3 = divisor high.
REQ-013 SHALL compose status as: bit0 rx_full, bit1 tx_busy, bit2 overrun, bit3 frame_err, bit7 irq_en; all other bits read 0.
REQ-014 SHALL, on a status write, update irq_en from din[7] and ignore all other bits.
REQ-015 SHALL capture a read on the clk edge where cs=1 and we=0, and present the value on dout from that edge on; dout holds its value otherwise (one-cycle read latency).
REQ-016 SHALL clear rx_full, overrun and frame_err on the same edge that captures a data-register read.
REQ-017 SHALL keep rx_full=1 when a read clear and a new stop-bit completion share an edge; the new byte is loaded and overrun is unchanged.
REQ-018 SHALL, on a data write while the TX FSM is IDLE, latch din and enter START on that edge; tx_busy=1 from the next cycle.
REQ-019 SHALL discard a data write while tx_busy=1, with no state change.
REQ-020 SHALL run the TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE; each bit lasts exactly div clocks; TX=0 in START, data bit in DATA, 1 in STOP and IDLE.
REQ-021 SHALL pass RX through a 2-flop synchronizer before any use.
REQ-022 SHALL run the RX FSM IDLE->START on a synchronized 1->0 transition.
REQ-023 SHALL, in START, resample at div/2 clocks: low -> DATA; high -> IDLE (glitch rejected, no flags set).
REQ-024 SHALL, in DATA, sample 8 bits LSB first at div-clock intervals, then sample STOP.
REQ-025 SHALL handle the STOP sample as: high with rx_full=0 -> load rx_data, set rx_full; high with rx_full=1 -> keep old rx_data, set overrun; low -> discard byte, set frame_err. It SHALL return to IDLE in all three cases.
REQ-026 SHALL hold div as a 16-bit register written bytewise via regs 2/3, with values below 2 treated as 2.
REQ-027 SHALL latch div into each FSM only at frame start, so mid-frame divisor writes affect the next frame only.
REQ-028 SHALL drive irq = irq_en & (rx_full | overrun | frame_err) as a registered output.
REQ-029 SHALL ignore all bus inputs when cs=0.

Reset
REQ-030 SHALL, while reset=0, force: both FSMs IDLE; TX=1; dout=0x00; irq=0; rx_full, overrun, frame_err, irq_en = 0; div=DEFAULT_DIV; synchronizer flops=1.
REQ-031 SHALL abort any frame in progress on reset assertion, with TX returning high immediately.
REQ-032 SHALL act on no bus access until the first clk edge after reset deasserts.

Verification
REQ-033 SHALL cover: div=16, write 0x55 to reg0 -> TX low 16 clocks, then 1,0,1,0,1,0,1,0 at 16 clocks each, then high 16 clocks; status bit1 = 1 during the frame, 0 after.
REQ-034 SHALL cover: RX frame 0xA3, then read reg1 -> 0x01; read reg0 -> 0xA3; read reg1 -> 0x00.
REQ-035 SHALL cover: two frames 0x11, 0x22 with no read in between -> reg0 = 0x11 and status = 0x05.
REQ-036 SHALL cover: frame with low stop bit -> status = 0x08, rx_full stays 0; an RX low pulse of 4 clocks -> no flags set.
REQ-037 SHALL cover: write 0x80 to reg1, receive one byte -> irq = 1; read reg0 -> irq = 0 one cycle later.
REQ-038 SHALL cover: reset asserted mid-TX-frame -> TX = 1 at once, and status reads 0x00 after release.

Source files
------------

// File: rtl/bus_uart.sv
// Memory-mapped UART: CPU register page (data, status/control, 16-bit divisor)
// in front of independent TX and RX serial engines sharing one clocks-per-bit divisor.
module bus_uart #(
   parameter int unsigned DEFAULT_DIV = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq,
   input  logic       RX,
   output logic       TX,
   output logic [1:0] tx_state_dbg,
   output logic [1:0] rx_state_dbg
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);

   // Bus handshake: an access is a single cycle with cs=1 sampled on the clk edge;
   // reads return on dout from that edge on, writes take effect on that edge.
   logic data_wr, data_rd, stat_wr, divl_wr, divh_wr, any_rd;
   assign data_wr = cs &  we & (addr == 2'd0);
   assign data_rd = cs & ~we & (addr == 2'd0);
   assign stat_wr = cs &  we & (addr == 2'd1);
   assign divl_wr = cs &  we & (addr == 2'd2);
   assign divh_wr = cs &  we & (addr == 2'd3);
   assign any_rd  = cs & ~we;

   logic [15:0] div_q, div_d, eff_div;
   assign eff_div = (div_q < 16'd2) ? 16'd2 : div_q;

   // ---------------- TX engine ----------------
   state_e      tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_end, tx_busy;

   assign tx_end  = (tx_cnt_q == tx_div_q - 16'd1);
   assign tx_busy = (tx_state_q != S_IDLE);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      case (tx_state_q)
         S_IDLE: if (data_wr) begin
            tx_shift_d = din;
            tx_div_d   = eff_div;
            tx_cnt_d   = 16'd0;
            tx_state_d = S_START;
         end
         S_START: if (tx_end) begin
            tx_cnt_d   = 16'd0;
            tx_bit_d   = 3'd0;
            tx_state_d = S_DATA;
         end else tx_cnt_d = tx_cnt_q + 16'd1;
         S_DATA: if (tx_end) begin
            tx_cnt_d   = 16'd0;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
         end else tx_cnt_d = tx_cnt_q + 16'd1;
         default: if (tx_end) begin
            tx_cnt_d   = 16'd0;
            tx_state_d = S_IDLE;
         end else tx_cnt_d = tx_cnt_q + 16'd1;
      endcase
   end

   // Decoded from registered state so reset forces the line high without waiting for a clock.
   always_comb begin
      TX = 1'b1;
      if (tx_state_q == S_START)     TX = 1'b0;
      else if (tx_state_q == S_DATA) TX = tx_shift_q[0];
   end

   // ---------------- RX engine ----------------
   state_e      rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_fall, rx_end;
   logic        stop_ok, stop_bad;

   assign rx_half = rx_div_q >> 1;
   assign rx_end  = (rx_cnt_q == rx_div_q - 16'd1);
   assign rx_fall = rx_s3_q & ~rx_s2_q;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_div_d   = rx_div_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      stop_ok    = 1'b0;
      stop_bad   = 1'b0;
      case (rx_state_q)
         S_IDLE: if (rx_fall) begin
            rx_div_d   = eff_div;
            rx_cnt_d   = 16'd0;
            rx_state_d = S_START;
         end
         S_START: if (rx_cnt_q == rx_half - 16'd1) begin
            rx_cnt_d   = 16'd0;
            rx_bit_d   = 3'd0;
            rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
         end else rx_cnt_d = rx_cnt_q + 16'd1;
         S_DATA: if (rx_end) begin
            rx_cnt_d   = 16'd0;
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
         end else rx_cnt_d = rx_cnt_q + 16'd1;
         default: if (rx_end) begin
            rx_cnt_d   = 16'd0;
            rx_state_d = S_IDLE;
            stop_ok    = rx_s2_q;
            stop_bad   = ~rx_s2_q;
         end else rx_cnt_d = rx_cnt_q + 16'd1;
      endcase
   end

   // ---------------- Register page ----------------
   logic       rx_full_q, rx_full_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic       irq_en_q, irq_en_d, irq_q, irq_d;
   logic [7:0] rx_data_q, rx_data_d, dout_q, dout_d, status, rd_mux;

   assign status = {irq_en_q, 3'b000, frame_err_q, overrun_q, tx_busy, rx_full_q};

   always_comb begin
      rx_full_d   = rx_full_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;
      rx_data_d   = rx_data_q;
      irq_en_d    = irq_en_q;
      div_d       = div_q;
      if (data_rd) begin
         rx_full_d   = 1'b0;
         overrun_d   = 1'b0;
         frame_err_d = 1'b0;
      end
      // A byte landing on the same edge as the read that frees the holding register is kept.
      if (stop_ok) begin
         if (!rx_full_q || data_rd) begin
            rx_data_d = rx_shift_q;
            rx_full_d = 1'b1;
            overrun_d = overrun_q;
         end else overrun_d = 1'b1;
      end
      if (stop_bad) frame_err_d = 1'b1;
      if (stat_wr)  irq_en_d    = din[7];
      if (divl_wr)  div_d[7:0]  = din;
      if (divh_wr)  div_d[15:8] = din;
      case (addr)
         2'd0:    rd_mux = rx_data_q;
         2'd1:    rd_mux = status;
         2'd2:    rd_mux = div_q[7:0];
         default: rd_mux = div_q[15:8];
      endcase
      dout_d = any_rd ? rd_mux : dout_q;
      irq_d  = irq_en_q & (rx_full_q | overrun_q | frame_err_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_q  <= S_IDLE;
         tx_cnt_q    <= 16'd0;
         tx_div_q    <= 16'd2;
         tx_bit_q    <= 3'd0;
         tx_shift_q  <= 8'h00;
         rx_state_q  <= S_IDLE;
         rx_cnt_q    <= 16'd0;
         rx_div_q    <= 16'd2;
         rx_bit_q    <= 3'd0;
         rx_shift_q  <= 8'h00;
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_s3_q     <= 1'b1;
         rx_full_q   <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         rx_data_q   <= 8'h00;
         irq_en_q    <= 1'b0;
         irq_q       <= 1'b0;
         div_q       <= DIV_RST;
         dout_q      <= 8'h00;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_div_q    <= tx_div_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_div_q    <= rx_div_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_s1_q     <= RX;
         rx_s2_q     <= rx_s1_q;
         rx_s3_q     <= rx_s2_q;
         rx_full_q   <= rx_full_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         rx_data_q   <= rx_data_d;
         irq_en_q    <= irq_en_d;
         irq_q       <= irq_d;
         div_q       <= div_d;
         dout_q      <= dout_d;
      end
   end

   assign dout         = dout_q;
   assign irq          = irq_q;
   assign tx_state_dbg = tx_state_q;
   assign rx_state_dbg = rx_state_q;

endmodule

// File: tb/tb_bus_uart.sv
// Self-checking bench for bus_uart: register vectors, directed serial frames,
// and a randomized phase checked against a flag/byte-level model.
module tb_bus_uart;

   logic       clk = 1'b0;
   logic       reset, cs, we, RX;
   logic [1:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       irq, TX;
   logic [1:0] tx_state_dbg, rx_state_dbg;

   bus_uart #(.DEFAULT_DIV(16)) dut (
      .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din),
      .dout(dout), .irq(irq), .RX(RX), .TX(TX),
      .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
   );

   // ---------------- clock / reset / cycle log ----------------
   always #5 clk = ~clk;

   localparam int LOGN = 30000;
   int   cyc = 0;
   logic tx_log [0:LOGN-1];
   always @(posedge clk) cyc = cyc + 1;
   always @(negedge clk) if (cyc < LOGN) tx_log[cyc] = TX;

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- model state ----------------
   logic [7:0] exp_q[$];
   logic       m_full, m_ov, m_fe, m_en;

   function automatic logic [7:0] m_status();
      return {m_en, 3'b000, m_fe, m_ov, 1'b0, m_full};
   endfunction

   function automatic void model_rx(input logic [7:0] b, input logic stop);
      if (!stop) m_fe = 1'b1;
      else if (!m_full) begin
         exp_q.push_back(b);
         m_full = 1'b1;
      end else m_ov = 1'b1;
   endfunction

   // ---------------- checks ----------------
   task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
      end
   endtask

   // Expected line level k cycles into a frame: start bit, 8 data bits LSB first, stop bit.
   task automatic check_tx(input string nm, input int st, input logic [7:0] b, input int d);
      int   bad, first;
      logic e, got;
      bad = 0; first = -1; got = 1'b0; e = 1'b0;
      for (int k = 0; k < 10 * d; k++) begin
         logic ek;
         if (k < d)          ek = 1'b0;
         else if (k < 9 * d) ek = b[(k - d) / d];
         else                ek = 1'b1;
         if (st + k >= LOGN || tx_log[st + k] !== ek) begin
            if (first < 0) begin
               first = k;
               e = ek;
               got = (st + k < LOGN) ? tx_log[st + k] : 1'bx;
            end
            bad++;
         end
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL %s: %0d bad cycles, first at cycle %0d got %b expected %b", nm, bad, first, got, e);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic bus(input logic c, input logic w, input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = c; we = w; addr = a; din = d;
      @(posedge clk);
      #1;
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus(1'b1, 1'b1, a, d);
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] v);
      bus(1'b1, 1'b0, a, 8'h00);
      v = dout;
   endtask

   task automatic tx_send(input logic [7:0] b, output int st);
      wr(2'd0, b);
      st = cyc;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
      @(negedge clk);
      RX = 1'b0;
      repeat (d) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (d) @(negedge clk);
      end
      RX = stop;
      repeat (d) @(negedge clk);
      RX = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic set_div(input int d);
      wr(2'd2, 8'(d));
      wr(2'd3, 8'(d >> 8));
   endtask

   // ---------------- register vectors ----------------
   typedef struct {
      logic       c;
      logic       w;
      logic [1:0] a;
      logic [7:0] d;
      logic       chk;
      logic [7:0] exp;
   } vec_t;

   vec_t vt[15];

   initial begin
      logic [7:0] v;
      int         st;

      reset = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00; RX = 1'b1;
      #1;
      check8("reset_tx",   {7'b0, TX},  8'h01);
      check8("reset_irq",  {7'b0, irq}, 8'h00);
      check8("reset_dout", dout,        8'h00);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      rd(2'd2, v); check8("reset_div_lo", v, 8'h10);
      rd(2'd3, v); check8("reset_div_hi", v, 8'h00);
      rd(2'd1, v); check8("reset_status", v, 8'h00);

      vt[0]  = '{1'b1, 1'b1, 2'd2, 8'h34, 1'b0, 8'h00};
      vt[1]  = '{1'b1, 1'b1, 2'd3, 8'h12, 1'b0, 8'h00};
      vt[2]  = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 8'h34};
      vt[3]  = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 8'h12};
      vt[4]  = '{1'b1, 1'b1, 2'd1, 8'h7F, 1'b0, 8'h00};
      vt[5]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 8'h00};
      vt[6]  = '{1'b1, 1'b1, 2'd1, 8'h80, 1'b0, 8'h00};
      vt[7]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 8'h80};
      vt[8]  = '{1'b0, 1'b1, 2'd2, 8'hAA, 1'b0, 8'h00};
      vt[9]  = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 8'h34};
      vt[10] = '{1'b0, 1'b0, 2'd3, 8'h00, 1'b1, 8'h34};
      vt[11] = '{1'b1, 1'b1, 2'd1, 8'h00, 1'b0, 8'h00};
      vt[12] = '{1'b1, 1'b1, 2'd2, 8'h10, 1'b0, 8'h00};
      vt[13] = '{1'b1, 1'b1, 2'd3, 8'h00, 1'b0, 8'h00};
      vt[14] = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 8'h00};
      for (int i = 0; i < 15; i++) begin
         bus(vt[i].c, vt[i].w, vt[i].a, vt[i].d);
         if (vt[i].chk) check8($sformatf("vec%0d", i), dout, vt[i].exp);
      end

      // TX frame, busy flag, write discarded while busy
      tx_send(8'h55, st);
      rd(2'd1, v); check8("tx_busy_status", v, 8'h02);
      wr(2'd0, 8'h00);
      repeat (165) @(negedge clk);
      check_tx("tx_frame_55", st, 8'h55, 16);
      rd(2'd1, v); check8("tx_idle_status", v, 8'h00);

      // divisor written mid-frame only affects the next frame
      tx_send(8'h5A, st);
      set_div(8);
      repeat (165) @(negedge clk);
      check_tx("tx_div_latched", st, 8'h5A, 16);
      tx_send(8'hC3, st);
      repeat (85) @(negedge clk);
      check_tx("tx_div8", st, 8'hC3, 8);

      // divisor below 2 behaves as 2
      set_div(1);
      rd(2'd2, v); check8("div_raw_1", v, 8'h01);
      tx_send(8'h96, st);
      repeat (25) @(negedge clk);
      check_tx("tx_div_min", st, 8'h96, 2);
      set_div(16);

      // RX directed
      send_rx(8'hA3, 1'b1, 16);
      rd(2'd1, v); check8("rx_a3_status", v, 8'h01);
      rd(2'd0, v); check8("rx_a3_data", v, 8'hA3);
      rd(2'd1, v); check8("rx_a3_cleared", v, 8'h00);

      send_rx(8'h11, 1'b1, 16);
      send_rx(8'h22, 1'b1, 16);
      rd(2'd1, v); check8("overrun_status", v, 8'h05);
      rd(2'd0, v); check8("overrun_data", v, 8'h11);
      rd(2'd1, v); check8("overrun_cleared", v, 8'h00);

      send_rx(8'h5C, 1'b0, 16);
      rd(2'd1, v); check8("frame_err_status", v, 8'h08);
      rd(2'd0, v); check8("frame_err_data_kept", v, 8'h11);
      rd(2'd1, v); check8("frame_err_cleared", v, 8'h00);

      @(negedge clk); RX = 1'b0;
      repeat (4) @(negedge clk); RX = 1'b1;
      repeat (30) @(negedge clk);
      rd(2'd1, v); check8("glitch_no_flags", v, 8'h00);

      // interrupt
      wr(2'd1, 8'h80);
      send_rx(8'h3C, 1'b1, 16);
      check8("irq_set", {7'b0, irq}, 8'h01);
      rd(2'd0, v); check8("irq_data", v, 8'h3C);
      check8("irq_still_set_on_read_edge", {7'b0, irq}, 8'h01);
      @(posedge clk); #1;
      check8("irq_cleared", {7'b0, irq}, 8'h00);
      rd(2'd1, v); check8("irq_en_status", v, 8'h80);

      // reset in the middle of a TX frame
      tx_send(8'h00, st);
      repeat (40) @(negedge clk);
      check8("tx_low_before_reset", {7'b0, TX}, 8'h00);
      #2 reset = 1'b0;
      #1;
      check8("tx_high_on_reset", {7'b0, TX}, 8'h01);
      check8("dout_in_reset", dout, 8'h00);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      rd(2'd1, v); check8("status_after_reset", v, 8'h00);
      rd(2'd2, v); check8("div_after_reset", v, 8'h10);
      tx_send(8'hA5, st);
      repeat (165) @(negedge clk);
      check_tx("tx_after_reset", st, 8'hA5, 16);

      // randomized phase against the model
      m_full = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_en = 1'b1;
      wr(2'd1, 8'h80);
      for (int t = 0; t < 30; t++) begin
         int         d, act;
         logic [7:0] b;
         d   = $urandom_range(2, 12);
         act = (t == 0) ? 0 : $urandom_range(0, 4);
         b   = 8'($urandom);
         set_div(d);
         case (act)
            0: begin send_rx(b, 1'b1, d); model_rx(b, 1'b1); end
            1: begin send_rx(b, 1'b0, d); model_rx(b, 1'b0); end
            2: begin
               rd(2'd0, v);
               check8($sformatf("rand%0d_data", t), v, exp_q[$]);
               m_full = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
            end
            3: begin
               rd(2'd1, v);
               check8($sformatf("rand%0d_status", t), v, m_status());
            end
            default: begin
               tx_send(b, st);
               repeat (10 * d + 4) @(negedge clk);
               check_tx($sformatf("rand%0d_tx", t), st, b, d);
            end
         endcase
         repeat (2) @(negedge clk);
         check8($sformatf("rand%0d_irq", t), {7'b0, irq},
                {7'b0, m_en & (m_full | m_ov | m_fe)});
      end
      rd(2'd1, v); check8("rand_final_status", v, m_status());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
